multicycle_sequencer: RTL and testbench

Multi-cycle control FSM for the R4 RV32I core. It steps one instruction at a time through fetch, decode, execute, memory and writeback, and shares the single memory port between instruction fetch and load/store accesses. It takes the static control bits produced by the instruction decoder and produces the per-cycle write enables, memory handshake and PC update controls for the datapath. It also keeps a retired-instruction counter and a memory-timeout fault flag.

---
 rtl/multicycle_sequencer.sv | 155 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the R4 RV32I core: sequences fetch/decode/execute/memory/writeback
// over a single shared memory port, with a retired-instruction counter and memory-timeout fault.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 mem_ready,
  input  logic                 mem_write,
  input  logic                 mem_to_reg,
  input  logic                 reg_write,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 branch_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_we,
  output logic                 mdr_we,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic                 pc_src,
  output logic                 busy,
  output logic                 fault,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StFault  = 3'd7;

  logic [2:0]           state_q, state_d;
  logic [7:0]           wait_q, wait_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic [8:0]           wait_inc;
  logic                 retire;
  logic                 timed_out;

  assign wait_inc  = {1'b0, wait_q} + 9'd1;
  assign timed_out = (wait_inc >= 9'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    instret_d    = instret_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;

    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (timed_out) begin
          state_d = StFault;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (mem_to_reg || mem_write) begin
          state_d = StMem;
        end else if (branch) begin
          pc_we  = 1'b1;
          pc_src = branch_taken;
          retire = 1'b1;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = mem_write;
        if (mem_ready) begin
          if (mem_write) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            mdr_we  = 1'b1;
            state_d = StWb;
          end
        end else if (timed_out) begin
          state_d = StFault;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      StWb: begin
        rf_we  = reg_write;
        pc_we  = 1'b1;
        pc_src = jump;
        retire = 1'b1;
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase

    if (retire) begin
      instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
      state_d   = run ? StFetch : StIdle;
    end

    // Each memory phase gets its own fresh wait budget.
    if (state_d != state_q && (state_d == StFetch || state_d == StMem)) wait_d = 8'd0;

    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      mdr_we       = 1'b0;
      rf_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 1'b0;
    end
  end

  assign busy    = ~reset && (state_q >= StFetch) && (state_q <= StWb);
  assign fault   = ~reset && (state_q == StFault);
  assign state   = reset ? StIdle : state_q;
  assign instret = reset ? '0 : instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wait_q    <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: table of instruction classes, hand-written corner
// sequences, and randomized instruction streams against a per-instruction phase model.
module tb_multicycle_sequencer;

  localparam int TO = 4;
  localparam int IW = 4;
  localparam int KAlu = 0, KLd = 1, KSt = 2, KBr = 3, KJal = 4;

  logic clk = 1'b0;
  logic reset, run, mem_ready;
  logic mem_write, mem_to_reg, reg_write, branch, jump, branch_taken;
  logic mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_src, busy, fault;
  logic [2:0]    state;
  logic [IW-1:0] instret;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_instret;
  bit exp_idle;

  multicycle_sequencer #(.TIMEOUT(TO), .INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .branch(branch), .jump(jump), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .mdr_we(mdr_we), .rf_we(rf_we), .pc_we(pc_we), .pc_src(pc_src), .busy(busy),
    .fault(fault), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] ov(bit req, bit we, bit asel, bit ir, bit mdr, bit rf, bit pcw,
                                     bit pcs, bit bsy, bit flt, logic [2:0] st);
    return {req, we, asel, ir, mdr, rf, pcw, pcs, bsy, flt, st};
  endfunction

  task automatic chk_out(input string nm, input logic [12:0] exp);
    logic [12:0] got;
    got = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_src, busy, fault, state};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (req we asel ir mdr rf pcw pcs busy flt st)",
               nm, got, exp);
    end
  endtask

  task automatic chk_val(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
    #1 chk_out("in_reset", 13'd0);
    @(negedge clk);
    reset = 1'b0; exp_idle = 1'b1; exp_instret = 0;
    #1 chk_out("post_reset", 13'd0);
    chk_val("instret_after_reset", int'(instret), 0);
  endtask

  // Walks one instruction through its phases; fw/mw are wait cycles before mem_ready in
  // FETCH/MEM, and a wait of TO or more must end in FAULT.
  task automatic do_instr(input int k, input bit tk, input int fw, input int mw, input bit drop,
                          output int cyc, output bit flt);
    bit ld, st, br, rw;
    ld = (k == KLd); st = (k == KSt); br = (k == KBr);
    rw = (k == KAlu || k == KLd || k == KJal);
    cyc = 0; flt = 1'b0;
    mem_write = st; mem_to_reg = ld; reg_write = rw; branch = br;
    jump = (k == KJal); branch_taken = tk; mem_ready = 1'b0;
    if (exp_idle) begin
      run = 1'b1;
      #1 chk_out("idle", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
      @(negedge clk);
    end
    for (int i = 0; i <= fw && !flt; i++) begin
      if (i == TO) flt = 1'b1;
      else begin
        mem_ready = (i == fw);
        #1 chk_out("fetch", ov(1, 0, 0, mem_ready, 0, 0, 0, 0, 1, 0, 3'd1));
        cyc++;
        @(negedge clk);
      end
    end
    if (!flt) begin
      mem_ready = 1'($urandom_range(0, 1));
      if (drop) run = 1'b0;
      #1 chk_out("decode", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd2));
      cyc++;
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1 chk_out("exec", ov(0, 0, 0, 0, 0, 0, br, br & tk, 1, 0, 3'd3));
      cyc++;
      @(negedge clk);
      if (ld || st) begin
        for (int i = 0; i <= mw && !flt; i++) begin
          if (i == TO) flt = 1'b1;
          else begin
            mem_ready = (i == mw);
            #1 chk_out("mem", ov(1, st, 1, 0, ld & mem_ready, 0, st & mem_ready, 0, 1, 0, 3'd4));
            cyc++;
            @(negedge clk);
          end
        end
      end
      if (!flt && !br && !st) begin
        mem_ready = 1'($urandom_range(0, 1));
        #1 chk_out("wb", ov(0, 0, 0, 0, 0, rw, 1, k == KJal, 1, 0, 3'd5));
        cyc++;
        @(negedge clk);
      end
    end
    if (flt) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1 chk_out("fault", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd7));
    end else begin
      exp_instret = (exp_instret + 1) % (1 << IW);
      exp_idle = !run;
      #1 chk_val("instret", int'(instret), exp_instret);
    end
  endtask

  typedef struct {
    int kind;
    bit taken;
    int fw;
    int mw;
    int cycles;
  } vec_t;

  initial begin
    vec_t vecs[10];
    int cyc;
    bit flt;
    int k, fw, mw;

    vecs[0] = '{KAlu, 0, 0, 0, 4};
    vecs[1] = '{KLd,  0, 0, 0, 5};
    vecs[2] = '{KSt,  0, 0, 0, 4};
    vecs[3] = '{KBr,  1, 0, 0, 3};
    vecs[4] = '{KBr,  0, 0, 0, 3};
    vecs[5] = '{KJal, 0, 0, 0, 4};
    vecs[6] = '{KLd,  0, 0, 2, 7};
    vecs[7] = '{KSt,  0, 1, 1, 6};
    vecs[8] = '{KAlu, 0, 3, 0, 7};
    vecs[9] = '{KLd,  0, 3, 3, 11};

    reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
    mem_write = 0; mem_to_reg = 0; reg_write = 0; branch = 0; jump = 0; branch_taken = 0;
    reset_dut();

    foreach (vecs[i]) begin
      do_instr(vecs[i].kind, vecs[i].taken, vecs[i].fw, vecs[i].mw, 1'b0, cyc, flt);
      chk_val($sformatf("cycles_vec%0d", i), cyc, vecs[i].cycles);
    end

    // FETCH timeout: fault is sticky until reset regardless of inputs.
    reset_dut();
    do_instr(KAlu, 0, TO + 3, 0, 1'b0, cyc, flt);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1; run = 1'($urandom_range(0, 1));
      #1 chk_out("fault_sticky", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd7));
    end
    reset_dut();

    // MEM timeout on a load.
    do_instr(KLd, 0, 0, TO, 1'b0, cyc, flt);
    reset_dut();

    // run dropped during DECODE of a jal: completes, then parks in IDLE.
    do_instr(KJal, 0, 0, 0, 1'b1, cyc, flt);
    chk_out("idle_after_drop", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));

    // Reset in the middle of a MEM wait: no retire, mem_req gone.
    reset_dut();
    mem_write = 0; mem_to_reg = 1; reg_write = 1; branch = 0; jump = 0; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1 chk_out("mem_wait", ov(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3'd4));
    @(negedge clk);
    reset_dut();

    // Counter wrap at 2^IW retirements.
    for (int i = 0; i < (1 << IW); i++) begin
      do_instr(KAlu, 0, 0, 0, 1'b0, cyc, flt);
      if (i == (1 << IW) - 2) chk_val("instret_max", int'(instret), (1 << IW) - 1);
    end
    chk_val("instret_wrap", int'(instret), 0);

    // Random instruction stream.
    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 4);
      fw = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 2);
      mw = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 2);
      do_instr(k, 1'($urandom_range(0, 1)), fw, mw, ($urandom_range(0, 3) == 0), cyc, flt);
      if (flt) reset_dut();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
